// File: rtl/alu_exec_unit.sv
// alu_exec_unit
// Execute-stage ALU. Takes the 4-bit Operation code from the ALU controller
// and the two forwarded operands, computes the result, registers it, and hands
// it to the EX/MEM register over a valid/ready handshake.
//
// Shifts are iterative by default: one bit per cycle, with back-pressure on
// in_ready while a shift is running. Defining ALU_BARREL_SHIFT_EN replaces
// the iterative shifter with a single-cycle barrel shifter. The SHIFT state,
// accumulator and counter are then not built, and busy is tied low.
//
// Ports
//   clk        clock, all state on rising edge
//   reset      synchronous, active-high
//   flush      synchronous pipeline flush; discards any in-flight work
//   in_valid   Operation/SrcA/SrcB valid this cycle
//   in_ready   unit can accept this cycle
//   Operation  ALU operation code
//   SrcA       operand A (rs1 or PC)
//   SrcB       operand B (rs2 or immediate); SrcB[4:0] is the shift amount
//   out_valid  ALUResult valid
//   out_ready  EX/MEM consumes the result this cycle
//   ALUResult  registered result
//   busy       high while an iterative shift is in progress
module alu_exec_unit #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [3:0]       Operation,
   input  logic [WIDTH-1:0] SrcA,
   input  logic [WIDTH-1:0] SrcB,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] ALUResult,
   output logic             busy
);

   localparam int SHW = $clog2(WIDTH);

   localparam logic [3:0] OP_AND = 4'b0000;
   localparam logic [3:0] OP_XOR = 4'b0001;
   localparam logic [3:0] OP_OR  = 4'b0010;
   localparam logic [3:0] OP_ADD = 4'b0011;
   localparam logic [3:0] OP_SUB = 4'b0100;
   localparam logic [3:0] OP_EQ  = 4'b0101;
   localparam logic [3:0] OP_NE  = 4'b0110;
   localparam logic [3:0] OP_LT  = 4'b0111;
   localparam logic [3:0] OP_GE  = 4'b1000;
   localparam logic [3:0] OP_SRL = 4'b1001;
   localparam logic [3:0] OP_SLL = 4'b1010;
   localparam logic [3:0] OP_SRA = 4'b1011;
   localparam logic [3:0] OP_LUI = 4'b1100;

   // Single-cycle result for every op. In the iterative build this is only
   // used for shifts when the shift amount is 0, so the shift ops simply
   // pass SrcA and no barrel shifter is inferred.
   function automatic logic [WIDTH-1:0] alu_fn(input logic [3:0]       op,
                                               input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b);
      logic signed [WIDTH-1:0] sa;
      logic signed [WIDTH-1:0] sb;
      logic [WIDTH-1:0]        r;
`ifdef ALU_BARREL_SHIFT_EN
      logic [SHW-1:0]          sh;
      sh = b[SHW-1:0];
`endif
      sa = a;
      sb = b;
      r  = '0;
      case (op)
         OP_AND: r = a & b;
         OP_XOR: r = a ^ b;
         OP_OR:  r = a | b;
         OP_ADD: r = a + b;
         OP_SUB: r = a - b;
         OP_EQ:  r = {{(WIDTH-1){1'b0}}, (a == b)};
         OP_NE:  r = {{(WIDTH-1){1'b0}}, (a != b)};
         OP_LT:  r = {{(WIDTH-1){1'b0}}, (sa < sb)};
         OP_GE:  r = {{(WIDTH-1){1'b0}}, (sa >= sb)};
`ifdef ALU_BARREL_SHIFT_EN
         OP_SRL: r = a >> sh;
         OP_SLL: r = a << sh;
         OP_SRA: r = $unsigned(sa >>> sh);
`else
         OP_SRL, OP_SLL, OP_SRA: r = a;
`endif
         OP_LUI: r = b;
         default: r = '0;
      endcase
      return r;
   endfunction

`ifndef ALU_BARREL_SHIFT_EN
   // One bit of shift for the iterative shifter; SRA replicates the sign bit.
   function automatic logic [WIDTH-1:0] shift_step(input logic [3:0]       op,
                                                   input logic [WIDTH-1:0] v);
      logic [WIDTH-1:0] r;
      case (op)
         OP_SRL:  r = {1'b0, v[WIDTH-1:1]};
         OP_SLL:  r = {v[WIDTH-2:0], 1'b0};
         OP_SRA:  r = {v[WIDTH-1], v[WIDTH-1:1]};
         default: r = v;
      endcase
      return r;
   endfunction
`endif

`ifdef ALU_BARREL_SHIFT_EN
   typedef enum logic {
      S_IDLE = 1'b0,
      S_DONE = 1'b1
   } state_t;
`else
   typedef enum logic [1:0] {
      S_IDLE  = 2'b00,
      S_SHIFT = 2'b01,
      S_DONE  = 2'b10
   } state_t;
`endif

   state_t           state_p1;
   state_t           state_d;
   logic [WIDTH-1:0] result_p1;
   logic             accept;

`ifndef ALU_BARREL_SHIFT_EN
   logic [WIDTH-1:0] acc_p1;
   logic [SHW-1:0]   cnt_p1;
   logic [3:0]       op_p1;
   logic             is_shift;
   logic             start_shift;
   logic [WIDTH-1:0] step_val;

   assign is_shift    = (Operation == OP_SRL) || (Operation == OP_SLL) ||
                        (Operation == OP_SRA);
   assign start_shift = is_shift && (SrcB[SHW-1:0] != '0);
   assign step_val    = shift_step(op_p1, acc_p1);
`endif

   // A new op can enter while the current result is being consumed, which is
   // what gives one-per-cycle throughput with out_ready held high.
   assign in_ready  = !flush && ((state_p1 == S_IDLE) ||
                                 ((state_p1 == S_DONE) && out_ready));
   assign accept    = in_valid && in_ready;
   assign out_valid = (state_p1 == S_DONE);
   assign ALUResult = result_p1;

`ifdef ALU_BARREL_SHIFT_EN
   assign busy = 1'b0;
`else
   assign busy = (state_p1 == S_SHIFT);
`endif

   // Next-state logic: flush > accept > shift progress / consume.
   always_comb begin
      state_d = state_p1;
      if (flush) begin
         state_d = S_IDLE;
      end else if (accept) begin
`ifdef ALU_BARREL_SHIFT_EN
         state_d = S_DONE;
`else
         state_d = start_shift ? S_SHIFT : S_DONE;
`endif
      end else begin
         case (state_p1)
`ifndef ALU_BARREL_SHIFT_EN
            S_SHIFT: if (cnt_p1 == SHW'(1)) state_d = S_DONE;
`endif
            S_DONE:  if (out_ready) state_d = S_IDLE;
            default: state_d = state_p1;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) state_p1 <= S_IDLE;
      else       state_p1 <= state_d;
   end

   // Result register (and the shifter accumulator when built). Flush leaves
   // the data alone; the state going to IDLE is what discards it.
   always_ff @(posedge clk) begin
      if (reset) begin
         result_p1 <= '0;
`ifndef ALU_BARREL_SHIFT_EN
         acc_p1    <= '0;
         cnt_p1    <= '0;
         op_p1     <= '0;
`endif
      end else if (!flush) begin
`ifdef ALU_BARREL_SHIFT_EN
         if (accept) result_p1 <= alu_fn(Operation, SrcA, SrcB);
`else
         if (accept) begin
            if (start_shift) begin
               acc_p1 <= SrcA;
               cnt_p1 <= SrcB[SHW-1:0];
               op_p1  <= Operation;
            end else begin
               result_p1 <= alu_fn(Operation, SrcA, SrcB);
            end
         end else if (state_p1 == S_SHIFT) begin
            acc_p1 <= step_val;
            cnt_p1 <= cnt_p1 - SHW'(1);
            if (cnt_p1 == SHW'(1)) result_p1 <= step_val;
         end
`endif
      end
   end

endmodule

// File: doc/alu_exec_unit.md
# alu_exec_unit

Execute-stage arithmetic unit consuming the 4-bit `Operation` code produced by the ALU controller, plus the two forwarded operands from the ID/EX register. It computes the result, registers it, and presents it to the EX/MEM register under a valid/ready handshake. Shifts are iterative by default, one bit per cycle, so the unit back-pressures the pipeline through `in_ready` while a shift is in progress.

## Interface
- `WIDTH`, 32, operand and result width; must be 32 for RV32I.
- `clk` input 1: clock, all state on rising edge.
- `reset` input 1: synchronous, active-high.
- `flush` input 1: synchronous pipeline flush (branch mispredict/trap).
- `in_valid` input 1: operands and `Operation` valid this cycle.
- `in_ready` output 1: unit can accept on this cycle.
- `Operation` input 4: ALU operation code.
- `SrcA` input WIDTH: operand A (rs1 or PC).
- `SrcB` input WIDTH: operand B (rs2 or immediate); `SrcB[4:0]` is shift amount.
- `out_valid` output 1: `ALUResult` valid.
- `out_ready` input 1: EX/MEM register consumes the result this cycle.
- `ALUResult` output WIDTH: registered result.
- `busy` output 1: high in SHIFT state.

## Operation
- Operation codes:
  - 0000 AND; 0001 XOR; 0010 OR; 0011 ADD; 0100 SUB (A−B).
  - 0101 EQ (BEQ): result 1 if A==B, else 0.
  - 0110 NE (BNE).
  - 0111 signed A<B (SLT/SLTI/BLT).
  - 1000 signed A>=B (BGE).
  - 1001 SRL; 1010 SLL; 1011 SRA.
  - 1100 pass B (LUI).
  - 1101–1111 → result 0.
- Arithmetic is modulo 2^32; there is no overflow flag. Compare results are zero-extended 0/1.
- FSM states and transitions:
  - IDLE: waiting for input.
    - Accept with a non-shift op, or a shift with shamt 0 → DONE, result loaded.
    - Accept with a shift and shamt≠0 → SHIFT; load `acc=SrcA`, `cnt=shamt`, latch op.
  - SHIFT: each cycle shifts `acc` by 1 (logical right, left, or arithmetic right with sign fill) and decrements `cnt`. When `cnt==1` at the edge → DONE with final value.
  - DONE: `out_valid=1`, `ALUResult` held stable.
    - `out_ready` with no new accept → IDLE.
    - `out_ready` with a new accept → next DONE or SHIFT, as in IDLE.
    - `out_ready` low → hold.
- Handshake signals:
  - `in_ready = (state==IDLE) || (state==DONE && out_ready)`, gated low when `flush`.
  - Acceptance occurs when `in_valid && in_ready`.
  - Inputs are sampled only on acceptance; they may change freely afterwards.
- Flush:
  - State goes to IDLE, `out_valid` to 0, and any in-flight shift or result is discarded.
  - No input is accepted in the flush cycle.
- Reset:
  - State IDLE, `out_valid=0`, `ALUResult=0`, `busy=0`, internal `acc`/`cnt` cleared.
  - Reset mid-shift behaves like flush and also zeroes the result.

## Timing
- Non-shift op, or shift with shamt 0: accepted in cycle T → `out_valid` in T+1.
- Shift with shamt=n (1..31), without `ALU_BARREL_SHIFT_EN`:
  - SHIFT occupies T+1..T+n; `busy=1` in those cycles.
  - `out_valid` rises in T+n+1.
  - `in_ready=0` from T+1 until DONE with `out_ready`.
- Back-to-back: with `out_ready` held high, a new non-shift op is accepted every cycle (throughput 1/cycle).
- `ALUResult` changes only on the edge that enters DONE; it is stable while `out_valid && !out_ready`.
- Priority per edge: `reset` > `flush` > accept > SHIFT progress.

## Configuration
- `ALU_BARREL_SHIFT_EN` defined:
  - SRL/SLL/SRA are single-cycle combinational barrel shifts; the SHIFT state and counter are not built.
  - All ops have latency 1 and `busy` is tied 0.
- Undefined (default): iterative shifter as described, latency 1+shamt for shifts.

## Test plan
- Reset, then ADD `SrcA=5`, `SrcB=7` accepted at T → `out_valid=1`, `ALUResult=12` at T+1; SUB `3−5` next cycle → `0xFFFFFFFE`.
- Compares: BLT `A=0xFFFFFFFF`, `B=1` → result 1; BGE with the same operands → 0; BEQ `A=B=0x1234` → 1; BNE → 0.
- SRA `A=0x80000000`, `B=4` accepted at T:
  - Default build: `busy` in T+1..T+4, `in_ready=0`, `ALUResult=0xF8000000` with `out_valid` at T+5.
  - With macro: result at T+1.
- Hold: result 12 in DONE with `out_ready=0` for 3 cycles → `ALUResult` stays 12 and `in_ready=0`. Raising `out_ready` with `in_valid` (OR `0xF0|0x0F`) → `0xFF` next cycle.
- `flush` during SLL `A=1`, `B=20` at the 5th SHIFT cycle → next cycle IDLE, `out_valid=0`, `in_ready=1`; no result is ever presented.
- `reset` asserted in DONE and mid-SHIFT → next cycle `out_valid=0`, `ALUResult=0`, `busy=0`. Op 1110 → result 0.
